// File: rtl/dino_pkg.sv
// Shared definitions for the Dino game pipeline: controller states,
// LFSR seed/taps and screen geometry.
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16/14/13/11 expressed for a right-shifting register:
    // tap n sits at bit (16 - n), i.e. bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int SCREEN_W = 640;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR. Only reset reloads the seed, so the
// sequence position depends on how long the player waits between games.
module lfsr16
    import dino_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // Shift right every cycle, feeding the tap parity into the top bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/obstacle_field.sv
// Per-frame obstacle scroller and game-state controller.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; all game registers at reset values
//   RUN     | game active; frame_tick scrolls, spawns, scores, ramps speed
//   OVER    | collision latched; everything frozen until start
module obstacle_field
    import dino_pkg::*;
#(
    parameter int NUM_OBS           = 3,
    parameter int X_WIDTH           = 10,
    parameter int SPAWN_X           = SCREEN_W,
    parameter int SPEED_INIT        = 1,
    parameter int SPEED_MAX         = 6,
    parameter int SPEED_STEP_FRAMES = 512,
    parameter int GAP_MIN           = 40,
    parameter int GAP_RAND_MASK     = 6'h3F
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       start,
    input  logic                       hit_pixel,
    output logic [NUM_OBS*X_WIDTH-1:0] obs_x,
    output logic [NUM_OBS-1:0]         obs_valid,
    output logic [3:0]                 speed,
    output logic [15:0]                score,
    output logic                       running,
    output logic                       game_over
);

    localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam int CD_W  = 16;
    localparam int FC_W  = 16;

    game_state_t        state_q;
    game_state_t        state_d;
    logic [15:0]        lfsr_q;
    logic [CD_W-1:0]    spawn_cd;
    logic [FC_W-1:0]    frame_cnt;
    logic [X_WIDTH-1:0] speed_x;
    logic [X_WIDTH-1:0] shift_x [NUM_OBS];
    logic [NUM_OBS-1:0] shift_v;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               frame_upd;
    logic               restart;
    logic               spawn;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // A hit in the same cycle as a tick wins, so the tick is dropped.
    assign frame_upd = (state_q == ST_RUN) && frame_tick && !hit_pixel;
    assign restart   = (state_q == ST_OVER) && start;
    assign spawn     = (spawn_cd == '0) && free_found;
    assign speed_x   = X_WIDTH'(speed);

    assign running   = (state_q == ST_RUN);
    assign game_over = (state_q == ST_OVER);

    // Per-slot scroll: move left by speed, or retire instead of underflowing.
    for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
        logic [X_WIDTH-1:0] x_cur;
        logic               retire;

        assign x_cur      = obs_x[g*X_WIDTH +: X_WIDTH];
        assign retire     = obs_valid[g] && (x_cur < speed_x);
        assign shift_v[g] = obs_valid[g] && !retire;
        assign shift_x[g] = !obs_valid[g] ? x_cur :
                            retire        ? '0    : (x_cur - speed_x);
    end

    // Lowest-index slot that is free after this tick's retirements.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (!shift_v[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start in RUN is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (hit_pixel) state_d = ST_OVER;
            ST_OVER: if (start)     state_d = ST_RUN;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Game datapath: cleared on reset or restart, advanced once per RUN frame.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            obs_x     <= '0;
            obs_valid <= '0;
            speed     <= 4'(SPEED_INIT);
            score     <= '0;
            spawn_cd  <= CD_W'(GAP_MIN);
            frame_cnt <= '0;
        end else if (frame_upd) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (spawn && (free_idx == IDX_W'(i))) begin
                    obs_x[i*X_WIDTH +: X_WIDTH] <= X_WIDTH'(SPAWN_X);
                    obs_valid[i]                <= 1'b1;
                end else begin
                    obs_x[i*X_WIDTH +: X_WIDTH] <= shift_x[i];
                    obs_valid[i]                <= shift_v[i];
                end
            end

            // With every slot busy the countdown parks at zero and retries.
            if (spawn_cd != '0) begin
                spawn_cd <= spawn_cd - CD_W'(1);
            end else if (free_found) begin
                spawn_cd <= CD_W'(GAP_MIN) + (lfsr_q & CD_W'(GAP_RAND_MASK));
            end

            if (score != 16'hFFFF) begin
                score <= score + 16'd1;
            end

            if (frame_cnt == FC_W'(SPEED_STEP_FRAMES - 1)) begin
                frame_cnt <= '0;
                if (speed < 4'(SPEED_MAX)) begin
                    speed <= speed + 4'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_obstacle_field.sv
// Bench for obstacle_field: default instance checked every cycle against a
// behavioural game model, plus a one-slot instance driven from a vector table.
module tb_obstacle_field;

    localparam int NO = 3;
    localparam int XW = 10;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OVER = 2;

    logic clk = 1'b0;
    logic reset, frame_tick, start, hit_pixel;
    logic [NO*XW-1:0] obs_x;
    logic [NO-1:0]    obs_valid;
    logic [3:0]       speed;
    logic [15:0]      score;
    logic             running, game_over;

    logic        frame_tick1, start1, hit1;
    logic [9:0]  obs_x1;
    logic        obs_valid1;
    logic [3:0]  speed1;
    logic [15:0] score1;
    logic        running1, game_over1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obstacle_field dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .hit_pixel(hit_pixel), .obs_x(obs_x), .obs_valid(obs_valid),
        .speed(speed), .score(score), .running(running), .game_over(game_over)
    );

    obstacle_field #(
        .NUM_OBS(1), .X_WIDTH(10), .SPAWN_X(15), .SPEED_INIT(4), .SPEED_MAX(6),
        .SPEED_STEP_FRAMES(512), .GAP_MIN(2), .GAP_RAND_MASK(0)
    ) dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick1), .start(start1),
        .hit_pixel(hit1), .obs_x(obs_x1), .obs_valid(obs_valid1),
        .speed(speed1), .score(score1), .running(running1), .game_over(game_over1)
    );

    // ---------------- behavioural model of the default instance ----------------
    int          m_state;
    int          m_x [NO];
    bit          m_v [NO];
    int          m_speed, m_score, m_cd, m_fc;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NO; i++) begin
            m_x[i] = 0;
            m_v[i] = 0;
        end
        m_speed = 1;
        m_score = 0;
        m_cd    = 40;
        m_fc    = 0;
    endtask

    task automatic model_frame();
        int slot;
        slot = -1;
        for (int i = 0; i < NO; i++) begin
            if (m_v[i]) begin
                if (m_x[i] >= m_speed) m_x[i] = m_x[i] - m_speed;
                else begin
                    m_v[i] = 0;
                    m_x[i] = 0;
                end
            end
        end
        if (m_cd == 0) begin
            for (int i = NO - 1; i >= 0; i--) if (!m_v[i]) slot = i;
            if (slot >= 0) begin
                m_x[slot] = 640;
                m_v[slot] = 1;
                m_cd = 40 + int'(m_lfsr & 16'h003F);
            end
        end else begin
            m_cd = m_cd - 1;
        end
        if (m_score < 65535) m_score = m_score + 1;
        m_fc = m_fc + 1;
        if (m_fc == 512) begin
            m_fc = 0;
            if (m_speed < 6) m_speed = m_speed + 1;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_clear();
            m_state = M_IDLE;
            m_lfsr  = 16'hACE1;
        end else begin
            if (m_state == M_IDLE) begin
                if (start) m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                if (hit_pixel) m_state = M_OVER;
                else if (frame_tick) model_frame();
            end else begin
                if (start) begin
                    model_clear();
                    m_state = M_RUN;
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NO*XW-1:0] ex;
        logic [NO-1:0]    ev;
        for (int i = 0; i < NO; i++) begin
            ex[i*XW +: XW] = XW'(m_x[i]);
            ev[i]          = m_v[i];
        end
        chk("model_obs_x", obs_x, ex);
        chk("model_obs_valid", obs_valid, ev);
        chk("model_speed", speed, m_speed);
        chk("model_score", score, m_score);
        chk("model_running", running, m_state == M_RUN);
        chk("model_game_over", game_over, m_state == M_OVER);
    endtask

    task automatic step(input bit t, input bit s, input bit h);
        frame_tick = t;
        start      = s;
        hit_pixel  = h;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        start      = 1'b0;
        hit_pixel  = 1'b0;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_obs_x"}, obs_x, 0);
        chk({tag, "_obs_valid"}, obs_valid, 0);
        chk({tag, "_speed"}, speed, 1);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_lfsr"}, dut.lfsr_q, 16'hACE1);
    endtask

    // ---------------- one-slot vector table ----------------
    typedef struct {
        bit          t, s, h;
        logic [9:0]  x;
        bit          v;
        logic [15:0] sc;
        bit          run, ov;
    } vec_t;

    function automatic vec_t mk(input bit t, input bit s, input bit h, input int x,
                                input bit v, input int sc, input bit run, input bit ov);
        vec_t r;
        r.t = t; r.s = s; r.h = h; r.x = 10'(x); r.v = v;
        r.sc = 16'(sc); r.run = run; r.ov = ov;
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [24];
        logic [29:0] saved_x;
        logic [15:0] saved_score;
        int          since_tick;
        int          max_speed;

        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; hit_pixel = 1'b0;
        frame_tick1 = 1'b0; start1 = 1'b0; hit1 = 1'b0;

        // Reset values.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Ticks in IDLE are ignored.
        repeat (10) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        chk("idle_valid", obs_valid, 0);
        chk("idle_score", score, 0);
        chk("idle_speed", speed, 1);
        chk("idle_running", running, 0);

        // First spawn after GAP_MIN+1 ticks, then scroll by one.
        step(0, 1, 0);
        chk("start_running", running, 1);
        repeat (41) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        chk("first_spawn_valid", obs_valid, 3'b001);
        chk("first_spawn_x", obs_x[XW-1:0], 640);
        step(1, 0, 0);
        chk("scroll_x", obs_x[XW-1:0], 639);
        chk("scroll_score", score, 42);

        // Hit and tick together: hit wins, everything frozen.
        step(0, 0, 0);
        saved_x     = obs_x;
        saved_score = score;
        step(1, 0, 1);
        chk("hit_game_over", game_over, 1);
        chk("hit_running", running, 0);
        chk("hit_obs_x_frozen", obs_x, saved_x);
        chk("hit_score_frozen", score, saved_score);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        chk("over_obs_x_frozen", obs_x, saved_x);
        chk("over_score_frozen", score, saved_score);
        chk("over_game_over", game_over, 1);
        step(0, 1, 0);
        chk("restart_running", running, 1);
        chk("restart_score", score, 0);
        chk("restart_valid", obs_valid, 0);
        chk("restart_game_over", game_over, 0);

        // Fill all three slots, then reset mid-run.
        for (int n = 0; n < 1500; n++) begin
            step(1, 0, 0);
            step(0, 0, 0);
            if (obs_valid == 3'b111) break;
        end
        chk("three_valid_reached", obs_valid, 3'b111);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midrun_reset");
        check_model();
        reset = 1'b0;

        // Random play against the model.
        step(0, 1, 0);
        since_tick = 2;
        for (int n = 0; n < 3000; n++) begin
            bit t, s, h;
            t = (since_tick >= 2) && ($urandom_range(2) == 0);
            s = ($urandom_range(149) == 0);
            h = ($urandom_range(399) == 0);
            step(t, s, h);
            since_tick = t ? 1 : since_tick + 1;
        end

        // Long hit-free run: speed ramps and saturates.
        if (running) step(0, 0, 1);
        step(0, 1, 0);
        max_speed = 0;
        for (int n = 0; n < 512 * 5 + 600; n++) begin
            step(1, 0, 0);
            step(0, 0, 0);
            if (int'(speed) > max_speed) max_speed = int'(speed);
        end
        chk("speed_saturated", speed, 6);
        chk("speed_max_seen", max_speed, 6);
        chk("long_run_score", score, 512 * 5 + 600);

        // One-slot instance: retire at x<speed and same-tick reuse.
        vt[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0,  0, 0, 0, 0, 0);
        vt[2]  = mk(1, 1, 0,  0, 0, 0, 1, 0);
        vt[3]  = mk(0, 0, 0,  0, 0, 0, 1, 0);
        vt[4]  = mk(1, 0, 0,  0, 0, 1, 1, 0);
        vt[5]  = mk(0, 0, 0,  0, 0, 1, 1, 0);
        vt[6]  = mk(1, 1, 0,  0, 0, 2, 1, 0);
        vt[7]  = mk(0, 0, 0,  0, 0, 2, 1, 0);
        vt[8]  = mk(1, 0, 0, 15, 1, 3, 1, 0);
        vt[9]  = mk(0, 0, 0, 15, 1, 3, 1, 0);
        vt[10] = mk(1, 0, 0, 11, 1, 4, 1, 0);
        vt[11] = mk(0, 0, 0, 11, 1, 4, 1, 0);
        vt[12] = mk(1, 0, 0,  7, 1, 5, 1, 0);
        vt[13] = mk(0, 0, 0,  7, 1, 5, 1, 0);
        vt[14] = mk(1, 0, 0,  3, 1, 6, 1, 0);
        vt[15] = mk(0, 0, 0,  3, 1, 6, 1, 0);
        vt[16] = mk(1, 0, 0, 15, 1, 7, 1, 0);
        vt[17] = mk(0, 0, 0, 15, 1, 7, 1, 0);
        vt[18] = mk(1, 0, 1, 15, 1, 7, 0, 1);
        vt[19] = mk(0, 0, 0, 15, 1, 7, 0, 1);
        vt[20] = mk(1, 0, 0, 15, 1, 7, 0, 1);
        vt[21] = mk(0, 0, 1, 15, 1, 7, 0, 1);
        vt[22] = mk(0, 0, 0, 15, 1, 7, 0, 1);
        vt[23] = mk(0, 1, 0,  0, 0, 0, 1, 0);

        for (int i = 0; i < 24; i++) begin
            frame_tick1 = vt[i].t;
            start1      = vt[i].s;
            hit1        = vt[i].h;
            @(posedge clk);
            @(negedge clk);
            frame_tick1 = 1'b0;
            start1      = 1'b0;
            hit1        = 1'b0;
            chk($sformatf("slot1_v%0d_x", i), obs_x1, vt[i].x);
            chk($sformatf("slot1_v%0d_valid", i), obs_valid1, vt[i].v);
            chk($sformatf("slot1_v%0d_score", i), score1, vt[i].sc);
            chk($sformatf("slot1_v%0d_running", i), running1, vt[i].run);
            chk($sformatf("slot1_v%0d_game_over", i), game_over1, vt[i].ov);
            chk($sformatf("slot1_v%0d_speed", i), speed1, 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obstacle_field.md
# obstacle_field

Per-frame obstacle scroller and game-state controller for the Dino VGA pipeline. It generalises the single hard-wired cactus to `NUM_OBS` independently tracked obstacles with pseudo-random spacing, a speed ramp, a frame score counter and a latched collision/game-over state machine. It sits between the VGA timing generator, which supplies the frame tick, and the pixel renderer, which consumes obstacle positions and returns the per-pixel hit flag.

## Interface
Parameters:
- `NUM_OBS`, 3: number of obstacle slots (1–8).
- `X_WIDTH`, 10: width of one obstacle x coordinate.
- `SPAWN_X`, 640: x loaded into a newly spawned obstacle.
- `SPEED_INIT`, 1: scroll speed in pixels/frame after reset or restart.
- `SPEED_MAX`, 6: speed ceiling.
- `SPEED_STEP_FRAMES`, 512: frames between speed increments.
- `GAP_MIN`, 40: minimum frames between spawns.
- `GAP_RAND_MASK`, 6'h3F: mask applied to the LFSR to form the random part of the gap.

Ports:
- `clk`, input, 1: 100 MHz system clock.
- `reset`, input, 1: synchronous, active-high.
- `frame_tick`, input, 1: one-`clk` pulse per frame, already synchronised to `clk`.
- `start`, input, 1: one-`clk` pulse from the jump/start button.
- `hit_pixel`, input, 1: renderer found a dino pixel overlapping an obstacle pixel this cycle.
- `obs_x`, output, `NUM_OBS*X_WIDTH`: packed left-edge x values; slot i is at `[i*X_WIDTH +: X_WIDTH]`.
- `obs_valid`, output, `NUM_OBS`: slot i is occupied and must be drawn.
- `speed`, output, 4: current scroll speed.
- `score`, output, 16: frames survived, saturating.
- `running`, output, 1: state is RUN.
- `game_over`, output, 1: state is OVER.

## Operation
- States: IDLE, RUN, OVER. Reset enters IDLE.
- All outputs are registered. Reset values:
  - `obs_x` = 0, `obs_valid` = 0
  - `speed` = `SPEED_INIT`
  - `score` = 0
  - `running` = 0, `game_over` = 0
  - spawn countdown = `GAP_MIN`, frame counter = 0
  - LFSR = 16'hACE1
- IDLE:
  - Outputs hold their reset values.
  - `start` → RUN.
  - `frame_tick` and `hit_pixel` are ignored.
- RUN, on `frame_tick`:
  - Each valid slot with `obs_x >= speed` gets `obs_x -= speed`.
  - A valid slot with `obs_x < speed` gets `obs_valid` cleared and `obs_x` = 0. There is no underflow.
  - Spawn countdown decrements.
  - When the countdown is 0 before decrement and a free slot exists, the lowest-index free slot (free after this tick's retirements) gets `obs_x` = `SPAWN_X` and `obs_valid` = 1. The countdown reloads with `GAP_MIN + (lfsr & GAP_RAND_MASK)`.
  - When the countdown is 0 and no slot is free, the countdown stays at 0 and the spawn is retried on the next tick.
  - `score` += 1, saturating at 16'hFFFF.
  - Frame counter += 1. When it reaches `SPEED_STEP_FRAMES`, it clears and `speed` += 1 if `speed < SPEED_MAX`.
- RUN, on `hit_pixel`: go to OVER. All obstacle, score and speed registers freeze.
- OVER:
  - `game_over` = 1; `frame_tick` and `hit_pixel` are ignored.
  - `start` reinitialises all state except the LFSR to reset values and enters RUN directly.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, advancing every `clk` in every state. Spawn gaps therefore depend on player timing. Reset reloads the seed; `start` does not.
- Simultaneous events:
  - `hit_pixel` and `frame_tick` in RUN: hit wins; no position or score update.
  - `start` and `frame_tick` in IDLE or OVER: start wins; the first update happens on the next tick.
  - `start` in RUN: ignored.
  - `reset` in any state and any cycle overrides everything.

## Timing
- Position, score and speed updates are visible on the cycle after `frame_tick`.
- `game_over` rises on the cycle after `hit_pixel`. `running` falls in the same cycle.
- `running` rises on the cycle after `start`.
- The first spawn occurs `GAP_MIN`+1 frame ticks after entering RUN.
- Retire, shift and spawn are all evaluated in the single `frame_tick` cycle. There is no multi-cycle sequencing.
- Throughput: one frame update per `frame_tick`. Ticks closer together than 2 `clk` are not supported.

## Structure
- Shared package `dino_pkg` holds:
  - state encoding (IDLE = 0, RUN = 1, OVER = 2)
  - LFSR seed 16'hACE1 and tap constants
  - the screen width constant 640
- Sub-module `lfsr16`: `clk`, `reset`, `q[15:0]`, free-running. Instantiated once.
- Slot logic uses a generate loop over `NUM_OBS`. The free-slot search is a priority encoder.

## Test plan
- Reset, then 10 `frame_tick` in IDLE → `obs_valid` = 0, `score` = 0, `speed` = 1, `running` = 0.
- `start`, then 41 ticks with `GAP_MIN` = 40 → slot 0 valid at x = 640. One more tick → x = 639, `score` = 42.
- Slot at x = 3 with `speed` = 4, then `frame_tick` → slot invalid, x = 0. With `NUM_OBS` = 1, a pending spawn reuses the slot in the same tick at x = 640.
- 512×5 + 600 ticks with no hits → `speed` saturates at 6 and never exceeds it.
- `hit_pixel` and `frame_tick` in the same cycle → `game_over` = 1 next cycle; `obs_x` and `score` unchanged afterwards. Then `start` → `running` = 1, `score` = 0, `obs_valid` = 0.
- `reset` asserted mid-RUN while three obstacles are valid → all outputs at reset values next cycle; LFSR back to 16'hACE1.
